// File: rtl/key_send_pkg.sv
// Shared definitions for the key/pulse_p serial transmitter.
// Defining KEY_SEND_PARITY_EN adds an even-parity bit after the LSB of each frame.
package key_send_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } key_send_state_t;

`ifdef KEY_SEND_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Number of bits transmitted per frame for a given code width.
    function automatic int frame_bits(input int code_len);
        return code_len + PARITY_BITS;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_sequence_sender_bit_period_counter.sv
// Bit-period divider: counts clocks within one transmitted bit and flags
// the cycle before mid-bit (so the strobe can be registered) and the last cycle.
module bit_period_counter
    import key_send_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_pre_mid,
    output logic o_last
);

    localparam int DIV_W = cnt_width(BIT_DIV);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] PRE_MID  = DIV_W'(BIT_DIV / 2 - 1);

    logic [DIV_W-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_div_cnt <= '0;
        end else if (i_en) begin
            r_div_cnt <= (r_div_cnt == LAST_DIV) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    assign o_pre_mid = (r_div_cnt == PRE_MID);
    assign o_last    = (r_div_cnt == LAST_DIV);

endmodule

// File: rtl/key_sequence_sender.sv
// Serial MSB-first code transmitter with a mid-bit pulse_p strobe and an inter-frame gap.
// Optional parity bit enabled by defining KEY_SEND_PARITY_EN.
module key_sequence_sender
    import key_send_pkg::*;
#(
    parameter int CODE_LEN = 4,
    parameter int BIT_DIV  = 4,
    parameter int GAP_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CODE_LEN-1:0] code,
    output logic                ready,
    output logic                busy,
    output logic                key,
    output logic                pulse_p,
    output logic                done
);

    localparam int N     = frame_bits(CODE_LEN);
    localparam int BIT_W = cnt_width(N + 1);
    localparam int GAP_W = cnt_width(GAP_CYC);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

    key_send_state_t  r_state, w_state_next;
    logic [N-1:0]     r_shift, w_shift_next;
    logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_next;
    logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_next;
    logic             r_ready, w_ready_next;
    logic             r_busy, w_busy_next;
    logic             r_key, w_key_next;
    logic             r_pulse_p, w_pulse_p_next;
    logic             r_done, w_done_next;

    logic             w_load;
    logic [N-1:0]     w_load_word;
    logic [N-1:0]     w_shift_left;
    logic             w_pre_mid;
    logic             w_div_last;

    assign w_load = (r_state == ST_IDLE) && r_ready && start;

`ifdef KEY_SEND_PARITY_EN
    assign w_load_word = {code, ^code};
`else
    assign w_load_word = code;
`endif

    generate
        if (N > 1) begin : g_shift_multi
            assign w_shift_left = {r_shift[N-2:0], 1'b0};
        end else begin : g_shift_single
            assign w_shift_left = '0;
        end
    endgenerate

    bit_period_counter #(
        .BIT_DIV(BIT_DIV)
    ) u_bit_period_counter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_en     (r_state == ST_SEND),
        .o_pre_mid(w_pre_mid),
        .o_last   (w_div_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_key     <= 1'b0;
            r_pulse_p <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_ready   <= w_ready_next;
            r_busy    <= w_busy_next;
            r_key     <= w_key_next;
            r_pulse_p <= w_pulse_p_next;
            r_done    <= w_done_next;
        end
    end

    // Outputs are computed one cycle early so every port comes straight from a flop.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_ready_next   = 1'b0;
        w_busy_next    = 1'b0;
        w_key_next     = 1'b0;
        w_pulse_p_next = 1'b0;
        w_done_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_ready_next = 1'b1;
                if (w_load) begin
                    w_state_next   = ST_SEND;
                    w_shift_next   = w_load_word;
                    w_bit_cnt_next = '0;
                    w_ready_next   = 1'b0;
                    w_busy_next    = 1'b1;
                    w_key_next     = w_load_word[N-1];
                end
            end
            ST_SEND: begin
                w_busy_next    = 1'b1;
                w_key_next     = r_key;
                w_pulse_p_next = w_pre_mid;
                if (w_div_last) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next   = ST_GAP;
                        w_gap_cnt_next = '0;
                        w_key_next     = 1'b0;
                    end else begin
                        w_shift_next   = w_shift_left;
                        w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                        w_key_next     = w_shift_left[N-1];
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == LAST_GAP) begin
                    w_state_next = ST_IDLE;
                    w_ready_next = 1'b1;
                    w_done_next  = 1'b1;
                end else begin
                    w_busy_next    = 1'b1;
                    w_gap_cnt_next = r_gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ready_next = 1'b1;
            end
        endcase
    end

    assign ready   = r_ready;
    assign busy    = r_busy;
    assign key     = r_key;
    assign pulse_p = r_pulse_p;
    assign done    = r_done;

endmodule

// File: tb/tb_key_sequence_sender.sv
// Bench for key_sequence_sender: cycle-timeline model for the outputs plus a
// frame scoreboard comparing bits captured at pulse_p against the accepted code.
module tb_key_sequence_sender;

    localparam int CL = 4;
    localparam int BD = 4;
    localparam int GC = 2;
`ifdef KEY_SEND_PARITY_EN
    localparam int NB = CL + 1;
`else
    localparam int NB = CL;
`endif
    localparam int FRAME_CYC = NB * BD + GC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CL-1:0] code;
    logic          ready, busy, key, pulse_p, done;

    int checks = 0;
    int errors = 0;

    logic [NB-1:0] sb_q[$];
    int            m_t = 0;
    logic [NB-1:0] m_bits = '0;
    logic          m_done;
    logic [NB-1:0] rx_bits = '0;
    int            rx_cnt = 0;

    always #5 clk = ~clk;

    key_sequence_sender #(
        .CODE_LEN(CL),
        .BIT_DIV (BD),
        .GAP_CYC (GC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .code   (code),
        .ready  (ready),
        .busy   (busy),
        .key    (key),
        .pulse_p(pulse_p),
        .done   (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [CL-1:0] c);
`ifdef KEY_SEND_PARITY_EN
        return {c, ^c};
`else
        return c;
`endif
    endfunction

    // One clock: apply inputs, advance the model past the edge, compare, score.
    task automatic cyc(input logic r, input logic s, input logic [CL-1:0] c);
        logic [4:0]    exp_v;
        logic          ekey, epulse;
        int            idx;
        logic [NB-1:0] want;
        rst   = r;
        start = s;
        code  = c;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (r) begin
            m_t = 0;
            sb_q.delete();
            rx_cnt  = 0;
            rx_bits = '0;
        end else if (m_t == 0) begin
            if (s) begin
                m_t    = 1;
                m_bits = frame_of(c);
                sb_q.push_back(m_bits);
            end
        end else if (m_t == FRAME_CYC) begin
            m_t    = 0;
            m_done = 1'b1;
        end else begin
            m_t++;
        end

        if (m_t == 0) begin
            exp_v = {1'b1, 1'b0, 1'b0, 1'b0, m_done};
        end else begin
            ekey   = 1'b0;
            epulse = 1'b0;
            if (m_t <= NB * BD) begin
                idx    = (m_t - 1) / BD;
                ekey   = m_bits[NB-1-idx];
                epulse = (((m_t - 1) % BD) == BD / 2);
            end
            exp_v = {1'b0, 1'b1, ekey, epulse, 1'b0};
        end
        check_eq("rdy_busy_key_pls_done", {27'd0, ready, busy, key, pulse_p, done}, {27'd0, exp_v});

        if (pulse_p) begin
            rx_bits = {rx_bits[NB-2:0], key};
            rx_cnt++;
        end
        if (done) begin
            check_eq("frame_pending", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                want = sb_q.pop_front();
                check_eq("frame_bits", {{(32-NB){1'b0}}, rx_bits}, {{(32-NB){1'b0}}, want});
                $display("frame done: sent %b received %b in %0d strobes", want, rx_bits, rx_cnt);
            end
            check_eq("frame_strobes", rx_cnt, NB);
            rx_cnt  = 0;
            rx_bits = '0;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        code  = '0;

        repeat (3) cyc(1'b1, 1'b0, '0);
        repeat (2) cyc(1'b0, 1'b0, '0);

        // Single frame 1011
        cyc(1'b0, 1'b1, 4'b1011);
        repeat (22) cyc(1'b0, 1'b0, CL'($urandom));

        // Start with a different code in cycle 5 must be ignored
        cyc(1'b0, 1'b1, 4'b1011);
        repeat (4) cyc(1'b0, 1'b0, CL'($urandom));
        cyc(1'b0, 1'b1, 4'b0000);
        repeat (18) cyc(1'b0, 1'b0, CL'($urandom));

        // Start held high: back-to-back frames
        repeat (3 * FRAME_CYC + 6) cyc(1'b0, 1'b1, CL'($urandom));
        repeat (FRAME_CYC + 2) cyc(1'b0, 1'b0, '0);

        // Reset mid-frame at cycle 9
        cyc(1'b0, 1'b1, 4'b1011);
        repeat (8) cyc(1'b0, 1'b0, CL'($urandom));
        cyc(1'b1, 1'b0, CL'($urandom));
        repeat (25) cyc(1'b0, 1'b0, CL'($urandom));

        // Reset and start together in IDLE
        cyc(1'b1, 1'b1, 4'b1111);
        repeat (5) cyc(1'b0, 1'b0, CL'($urandom));

        // Random frames with random start activity during and after
        for (int f = 0; f < 8; f++) begin
            cyc(1'b0, 1'b1, CL'($urandom));
            for (int i = 0; i < FRAME_CYC + int'($urandom_range(0, 3)); i++)
                cyc(1'b0, 1'($urandom_range(0, 1)), CL'($urandom));
        end
        repeat (FRAME_CYC + 3) cyc(1'b0, 1'b0, '0);

        check_eq("frames_left", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
